processing_element: RTL and testbench
=====================================

PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 Parameters SHALL be: depth, default 4, log2 of local buffer depth (D = 2^depth); A, default 7, length/shift field width; W, default 16, signed data width.
REQ-002 CLK  in  1  the single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset; synchronous, active-high.
REQ-004 adderIn  in  W  signed partial sum from the upstream PE.
REQ-005 controlSignal  in  8  per-cycle command bits.
- [0] stall
- [1] neuron write enable
- [2] kernel write enable
- [3] MAC start
- [4] bypass
- [5] add-adderIn enable
- [6] output latch
- [7] reserved, ignored
REQ-006 initSettings  in  depth  local buffer write address.
REQ-007 peConfig  in  2*depth+2*A  = {nBase[depth], kBase[depth], len[A], frac[A]}, MSB first.
REQ-008 kernelIn  in  W  signed kernel write data.
REQ-009 neuronIn  in  W  signed neuron write data.
REQ-010 adderOut  out  W  registered signed result to the downstream PE.

Function
REQ-011 The PE SHALL hold a neuron buffer NB and a kernel buffer KB, each D x W.
REQ-012 stall=1 SHALL freeze all state (buffers, counters, accumulator, adderOut) and override every other bit; RST still applies.
REQ-013 Buffer writes:
- nWe=1: NB[initSettings] <= neuronIn.
- kWe=1: KB[initSettings] <= kernelIn.
- Both writes MAY occur in the same cycle.
- A same-cycle read of the written address SHALL return the old value.
REQ-014 start=1 SHALL load nPtr<=nBase, kPtr<=kBase, cnt<=len, acc<=0, and set busy=1 iff len!=0.
- start SHALL restart any operation in progress.
REQ-015 While busy and not start:
- each cycle acc += NB[nPtr]*KB[kPtr] (signed).
- Both pointers SHALL increment modulo D (wrap 15->0).
- cnt SHALL decrement; busy SHALL clear on the edge where cnt goes 1->0.
REQ-016 Accumulator SHALL be signed 2W+A bits, so 127 full-scale products never overflow.
- Start sampled at edge k: products accumulate at edges k+1..k+len; busy=0 after edge k+len.
REQ-017 Result computation:
- s = acc >>> min(frac, 2W+A-1) (arithmetic shift).
- r = s + (addEn ? sign-extended adderIn : 0).
- res = r saturated to signed W range [-2^(W-1), 2^(W-1)-1].
REQ-018 adderOut update priority:
- bypass=1: adderOut <= adderIn (highest priority).
- else outLatch=1 and busy=0: adderOut <= res.
- else: adderOut holds.
- outLatch while busy SHALL be ignored.
REQ-019 bypass SHALL NOT disturb the MAC operation or the buffers.

Reset
REQ-020 RST SHALL clear adderOut, acc, busy, nPtr, kPtr, cnt, and all NB/KB entries to 0 on the next rising CLK; RST overrides stall and all commands.
REQ-021 RST asserted mid-operation SHALL abort it; no partial result SHALL appear on adderOut.

Structure
REQ-022 A shared package SHALL hold the default depth/A/W, the controlSignal bit indices, and the peConfig field offsets/widths.
REQ-023 One sub-module, pe_local_buffer (D x W, sync write, async read, sync clear), SHALL be instantiated twice, for NB and KB.

Verification
REQ-024 Write path: write NB[0..3]={1,2,3,4} and KB[0..3]={5,6,7,8}; start with nBase=0, kBase=0, len=4, frac=0; wait 4 cycles; outLatch -> adderOut=70.
REQ-025 Chaining: same data, addEn=1, adderIn=-10 -> adderOut=60; bypass=1, adderIn=0x1234 -> adderOut=0x1234 on the next edge.
REQ-026 Wrap and shift: NB[15]=NB[0]=256, KB[15]=KB[0]=256; nBase=kBase=15, len=2, frac=8 -> adderOut=512.
REQ-027 Saturation: NB[0]=KB[0]=32767, len=1, frac=0 -> adderOut=32767; NB[0]=-32768, KB[0]=32767 -> adderOut=-32768.
REQ-028 Control corners:
- len=0 -> adderOut=0.
- stall=1 for 3 cycles mid-MAC -> result unchanged and completion delayed by 3 cycles.
- outLatch while busy -> adderOut holds.
- RST mid-MAC -> adderOut=0, busy=0, buffers 0.

Source files
------------

// File: rtl/processing_element_pkg.sv
// Shared defaults, command-bit indices and peConfig field layout for the processing element.
package processing_element_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int A_DEFAULT     = 7;
  localparam int W_DEFAULT     = 16;

  localparam int CTRL_STALL     = 0;
  localparam int CTRL_N_WE      = 1;
  localparam int CTRL_K_WE      = 2;
  localparam int CTRL_START     = 3;
  localparam int CTRL_BYPASS    = 4;
  localparam int CTRL_ADD_EN    = 5;
  localparam int CTRL_OUT_LATCH = 6;

  // peConfig is {nBase, kBase, len, frac} with frac in the least significant bits.
  localparam int CFG_FRAC_LSB = 0;

  function automatic int cfg_len_lsb(input int a);
    return a;
  endfunction

  function automatic int cfg_kbase_lsb(input int a);
    return 2 * a;
  endfunction

  function automatic int cfg_nbase_lsb(input int depth, input int a);
    return 2 * a + depth;
  endfunction

  typedef enum logic {
    MAC_IDLE = 1'b0,
    MAC_BUSY = 1'b1
  } mac_state_e;

  typedef struct packed {
    logic stall;
    logic n_we;
    logic k_we;
    logic start;
    logic bypass;
    logic add_en;
    logic out_latch;
  } ctrl_t;

endpackage

// File: rtl/processing_element_local_buffer.sv
// D x W local operand store: synchronous write and clear, combinational read of the stored value.
module pe_local_buffer #(
  parameter int depth = 4,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [depth-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [depth-1:0] raddr,
  output logic [W-1:0]     rdata
);

  localparam int D = 1 << depth;

  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the registered contents, so a same-cycle write returns the old value.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/processing_element.sv
// Systolic processing element: local neuron/kernel buffers, a multiply-accumulate walk over them,
// and a shifted, chained, saturated result registered onto adderOut.
module processing_element
  import processing_element_pkg::*;
#(
  parameter int depth = DEPTH_DEFAULT,
  parameter int A     = A_DEFAULT,
  parameter int W     = W_DEFAULT
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic signed [W-1:0]       adderIn,
  input  logic [7:0]                controlSignal,
  input  logic [depth-1:0]          initSettings,
  input  logic [2*depth+2*A-1:0]    peConfig,
  input  logic signed [W-1:0]       kernelIn,
  input  logic signed [W-1:0]       neuronIn,
  output logic signed [W-1:0]       adderOut
);

  localparam int AW = 2 * W + A;
  localparam logic signed [AW:0] SAT_MAX = {{(AW + 1 - W){1'b0}}, 1'b0, {(W - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW + 1 - W){1'b1}}, 1'b1, {(W - 1){1'b0}}};

  ctrl_t                   ctrl;
  logic                    unused_reserved;
  logic [depth-1:0]        cfg_n_base, cfg_k_base;
  logic [A-1:0]            cfg_len, cfg_frac;

  mac_state_e              state_q, state_d;
  logic [depth-1:0]        n_ptr_q, n_ptr_d, k_ptr_q, k_ptr_d;
  logic [A-1:0]            cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [W-1:0]     adder_out_q, adder_out_d;

  logic                    nb_we, kb_we;
  logic signed [W-1:0]     n_rd, k_rd;
  logic signed [2*W-1:0]   prod;
  logic [A-1:0]            shift_amt;
  logic signed [AW-1:0]    shifted;
  logic signed [AW:0]      sum;
  logic signed [W-1:0]     res;

  assign unused_reserved = controlSignal[7];
  assign cfg_frac   = peConfig[CFG_FRAC_LSB +: A];
  assign cfg_len    = peConfig[cfg_len_lsb(A) +: A];
  assign cfg_k_base = peConfig[cfg_kbase_lsb(A) +: depth];
  assign cfg_n_base = peConfig[cfg_nbase_lsb(depth, A) +: depth];

  always_comb begin
    ctrl.stall     = controlSignal[CTRL_STALL];
    ctrl.n_we      = controlSignal[CTRL_N_WE];
    ctrl.k_we      = controlSignal[CTRL_K_WE];
    ctrl.start     = controlSignal[CTRL_START];
    ctrl.bypass    = controlSignal[CTRL_BYPASS];
    ctrl.add_en    = controlSignal[CTRL_ADD_EN];
    ctrl.out_latch = controlSignal[CTRL_OUT_LATCH];
  end

  assign nb_we = ctrl.n_we & ~ctrl.stall;
  assign kb_we = ctrl.k_we & ~ctrl.stall;

  pe_local_buffer #(.depth(depth), .W(W)) u_nb (
    .clk(CLK), .rst(RST), .we(nb_we), .waddr(initSettings), .wdata(neuronIn),
    .raddr(n_ptr_q), .rdata(n_rd)
  );

  pe_local_buffer #(.depth(depth), .W(W)) u_kb (
    .clk(CLK), .rst(RST), .we(kb_we), .waddr(initSettings), .wdata(kernelIn),
    .raddr(k_ptr_q), .rdata(k_rd)
  );

  // Result path: clamp the shift so huge frac values still leave the sign replicated.
  always_comb begin
    prod = $signed({{W{n_rd[W-1]}}, n_rd}) * $signed({{W{k_rd[W-1]}}, k_rd});
    if (int'(cfg_frac) > AW - 1) begin
      shift_amt = A'(AW - 1);
    end else begin
      shift_amt = cfg_frac;
    end
    shifted = acc_q >>> shift_amt;
    sum = {shifted[AW-1], shifted} + (ctrl.add_en ? {{(AW + 1 - W){adderIn[W-1]}}, adderIn} : '0);
    if (sum > SAT_MAX) begin
      res = SAT_MAX[W-1:0];
    end else if (sum < SAT_MIN) begin
      res = SAT_MIN[W-1:0];
    end else begin
      res = sum[W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    n_ptr_d     = n_ptr_q;
    k_ptr_d     = k_ptr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    adder_out_d = adder_out_q;
    if (!ctrl.stall) begin
      if (ctrl.start) begin
        n_ptr_d = cfg_n_base;
        k_ptr_d = cfg_k_base;
        cnt_d   = cfg_len;
        acc_d   = '0;
        state_d = (cfg_len != '0) ? MAC_BUSY : MAC_IDLE;
      end else if (state_q == MAC_BUSY) begin
        acc_d   = acc_q + $signed({{(AW - 2 * W){prod[2*W-1]}}, prod});
        n_ptr_d = n_ptr_q + depth'(1);
        k_ptr_d = k_ptr_q + depth'(1);
        cnt_d   = cnt_q - A'(1);
        if (cnt_q == A'(1)) begin
          state_d = MAC_IDLE;
        end
      end
      if (ctrl.bypass) begin
        adder_out_d = adderIn;
      end else if (ctrl.out_latch && state_q == MAC_IDLE) begin
        adder_out_d = res;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= MAC_IDLE;
      n_ptr_q     <= '0;
      k_ptr_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      adder_out_q <= '0;
    end else begin
      state_q     <= state_d;
      n_ptr_q     <= n_ptr_d;
      k_ptr_q     <= k_ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      adder_out_q <= adder_out_d;
    end
  end

  assign adderOut = adder_out_q;

endmodule

// File: tb/tb_processing_element.sv
// Scoreboard bench for processing_element: a transaction-level model predicts every adderOut value.
module tb_processing_element;
  import processing_element_pkg::*;

  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int A     = A_DEFAULT;
  localparam int W     = W_DEFAULT;
  localparam int D     = 1 << DEPTH;
  localparam int AW    = 2 * W + A;

  localparam logic [7:0] C_STALL  = 8'(1 << CTRL_STALL);
  localparam logic [7:0] C_NWE    = 8'(1 << CTRL_N_WE);
  localparam logic [7:0] C_KWE    = 8'(1 << CTRL_K_WE);
  localparam logic [7:0] C_START  = 8'(1 << CTRL_START);
  localparam logic [7:0] C_BYPASS = 8'(1 << CTRL_BYPASS);
  localparam logic [7:0] C_ADD    = 8'(1 << CTRL_ADD_EN);
  localparam logic [7:0] C_LATCH  = 8'(1 << CTRL_OUT_LATCH);

  logic                       CLK = 1'b0;
  logic                       RST;
  logic signed [W-1:0]        adderIn;
  logic [7:0]                 controlSignal;
  logic [DEPTH-1:0]           initSettings;
  logic [2*DEPTH+2*A-1:0]     peConfig;
  logic signed [W-1:0]        kernelIn;
  logic signed [W-1:0]        neuronIn;
  logic signed [W-1:0]        adderOut;

  typedef struct {
    int unsigned         cycle;
    logic signed [W-1:0] value;
    string               name;
  } exp_t;

  exp_t                exp_q[$];
  int unsigned         cycle_count = 0;
  int                  checks = 0;
  int                  errors = 0;
  int                  nb_model[D];
  int                  kb_model[D];
  logic signed [W-1:0] model_out;
  int                  cfg_n_base, cfg_k_base, cfg_len, cfg_frac;

  processing_element #(.depth(DEPTH), .A(A), .W(W)) dut (
    .CLK(CLK), .RST(RST), .adderIn(adderIn), .controlSignal(controlSignal),
    .initSettings(initSettings), .peConfig(peConfig), .kernelIn(kernelIn),
    .neuronIn(neuronIn), .adderOut(adderOut)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle_count <= cycle_count + 1;

  function automatic int randWord();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Reference: dot product over circularly indexed buffers, then shift, chain and clamp.
  function automatic logic signed [W-1:0] modelResult(input int n_base, input int k_base,
                                                       input int len, input int frac,
                                                       input bit add_en, input int ain);
    longint acc = 0;
    longint r;
    int     sh;
    for (int i = 0; i < len; i++) begin
      acc += longint'(nb_model[(n_base + i) % D]) * longint'(kb_model[(k_base + i) % D]);
    end
    sh = (frac > AW - 1) ? AW - 1 : frac;
    r = (acc >>> sh) + (add_en ? longint'(ain) : 64'sd0);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return W'(r);
  endfunction

  task automatic checkOutput(input string name, input logic signed [W-1:0] actual,
                             input logic signed [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: adderOut=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle_count);
    end
  endtask

  // Monitor: each expectation is tagged with the edge after which adderOut must hold it.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cycle <= cycle_count) begin
        e = exp_q.pop_front();
        checkOutput(e.name, adderOut, e.value);
      end
    end
  end

  task automatic expectOut(input string name, input logic signed [W-1:0] v);
    exp_t e;
    e.cycle = cycle_count + 1;
    e.value = v;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit rst, input logic [7:0] ctrl, input int addr,
                               input int nval, input int kval, input int ain);
    @(negedge CLK);
    RST           = rst;
    controlSignal = ctrl;
    initSettings  = DEPTH'(addr);
    neuronIn      = W'(nval);
    kernelIn      = W'(kval);
    adderIn       = W'(ain);
    peConfig      = {DEPTH'(cfg_n_base), DEPTH'(cfg_k_base), A'(cfg_len), A'(cfg_frac)};
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b1, 8'($urandom), int'($urandom_range(0, D - 1)), randWord(), randWord(), randWord());
    for (int i = 0; i < D; i++) begin
      nb_model[i] = 0;
      kb_model[i] = 0;
    end
    model_out = '0;
    expectOut(name, model_out);
  endtask

  task automatic writeBuf(input int addr, input int nval, input int kval, input bit n_we, input bit k_we);
    applyStimulus(1'b0, (n_we ? C_NWE : 8'h00) | (k_we ? C_KWE : 8'h00), addr, nval, kval, randWord());
    if (n_we) nb_model[addr] = nval;
    if (k_we) kb_model[addr] = kval;
    expectOut("write holds", model_out);
  endtask

  task automatic stallCycle(input string name);
    applyStimulus(1'b0, 8'($urandom) | C_STALL, int'($urandom_range(0, D - 1)),
                  randWord(), randWord(), randWord());
    expectOut({name, "/stall"}, model_out);
  endtask

  task automatic bypassOnly(input int ain, input string name);
    applyStimulus(1'b0, C_BYPASS, 0, 0, 0, ain);
    model_out = W'(ain);
    expectOut(name, model_out);
  endtask

  task automatic latchOnly(input bit add_en, input int ain, input string name);
    applyStimulus(1'b0, C_LATCH | (add_en ? C_ADD : 8'h00), 0, 0, 0, ain);
    model_out = modelResult(cfg_n_base, cfg_k_base, cfg_len, cfg_frac, add_en, ain);
    expectOut(name, model_out);
  endtask

  task automatic runMac(input int n_base, input int k_base, input int len, input int frac,
                        input bit add_en, input int ain, input int stall_at, input int stall_pct,
                        input int busy_latch_pct, input int bypass_pct, input string name);
    logic signed [W-1:0] result;
    int r;
    int ain_b;
    cfg_n_base = n_base;
    cfg_k_base = k_base;
    cfg_len    = len;
    cfg_frac   = frac;
    result = modelResult(n_base, k_base, len, frac, add_en, ain);
    applyStimulus(1'b0, C_START, 0, 0, 0, randWord());
    expectOut({name, "/start"}, model_out);
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < 3; s++) stallCycle(name);
      end
      if (int'($urandom_range(0, 99)) < stall_pct) stallCycle(name);
      r = int'($urandom_range(0, 99));
      if (r < bypass_pct) begin
        ain_b = randWord();
        bypassOnly(ain_b, {name, "/bypass busy"});
      end else if (r < bypass_pct + busy_latch_pct) begin
        applyStimulus(1'b0, C_LATCH, 0, 0, 0, randWord());
        expectOut({name, "/latch busy"}, model_out);
      end else begin
        applyStimulus(1'b0, 8'h00, 0, 0, 0, randWord());
        expectOut({name, "/idle"}, model_out);
      end
    end
    applyStimulus(1'b0, C_LATCH | (add_en ? C_ADD : 8'h00), 0, 0, 0, ain);
    model_out = result;
    expectOut(name, model_out);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b0; controlSignal = '0; initSettings = '0; peConfig = '0;
    adderIn = '0; kernelIn = '0; neuronIn = '0;
    cfg_n_base = 0; cfg_k_base = 0; cfg_len = 0; cfg_frac = 0;
    model_out = '0;

    doReset("reset");
    doReset("reset again");
    latchOnly(1'b0, 0, "latch after reset");

    for (int i = 0; i < 4; i++) writeBuf(i, i + 1, i + 5, 1'b1, 1'b1);
    runMac(0, 0, 4, 0, 1'b0, 0, -1, 0, 100, 0, "mac basic");
    latchOnly(1'b1, -10, "chain add");
    bypassOnly(16'h1234, "bypass");
    applyStimulus(1'b0, C_BYPASS | C_LATCH, 0, 0, 0, -7);
    model_out = -16'sd7;
    expectOut("bypass over latch", model_out);

    writeBuf(15, 256, 256, 1'b1, 1'b1);
    writeBuf(0, 256, 256, 1'b1, 1'b1);
    runMac(15, 15, 2, 8, 1'b0, 0, -1, 0, 0, 0, "wrap shift");

    writeBuf(0, 32767, 32767, 1'b1, 1'b1);
    runMac(0, 0, 1, 0, 1'b0, 0, -1, 0, 0, 0, "sat positive");
    writeBuf(0, -32768, 0, 1'b1, 1'b0);
    runMac(0, 0, 1, 0, 1'b0, 0, -1, 0, 0, 0, "sat negative");
    runMac(3, 5, 0, 0, 1'b0, 0, -1, 0, 0, 0, "len zero");

    for (int i = 0; i < 4; i++) writeBuf(i, i + 1, i + 5, 1'b1, 1'b1);
    runMac(0, 0, 4, 0, 1'b0, 0, 2, 0, 100, 0, "stall mid-mac");

    for (int t = 0; t < 40; t++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        writeBuf(int'($urandom_range(0, D - 1)), randWord(), randWord(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      runMac(int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 1)),
             int'($urandom_range(0, 20)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 127)),
             1'($urandom_range(0, 1)), randWord(), -1, 20, 30, 10, "random mac");
    end

    bypassOnly(16'h5555, "pre-abort bypass");
    cfg_n_base = 0; cfg_k_base = 0; cfg_len = 8; cfg_frac = 0;
    applyStimulus(1'b0, C_START, 0, 0, 0, 0);
    expectOut("abort/start", model_out);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 8'h00, 0, 0, 0, 0);
      expectOut("abort/idle", model_out);
    end
    doReset("reset mid-mac");
    bypassOnly(16'h7777, "post-abort bypass");
    latchOnly(1'b0, 0, "latch after abort");
    runMac(0, 0, 4, 0, 1'b1, 5, -1, 0, 0, 0, "buffers cleared");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 0, 0, 0, 0);
      expectOut("final idle", model_out);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
